// File: rtl/multiplier_arbiter.sv
// multiplier_arbiter: round-robin front end for one shared complex 2x2
// matrix multiplier. Registers the winning requester's operands, issues the
// multiplier start pulse, waits for the rising edge of mult_done and hands
// the product back to the granted requester with a one-cycle done pulse.
module multiplier_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int REQ_IDX_BITS = 2,
  parameter int NUMBER_BITS  = 18
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*8*NUMBER_BITS-1:0]  req_a,
  input  logic [NUM_REQ*8*NUMBER_BITS-1:0]  req_b,
  output logic [NUM_REQ-1:0]                req_grant,
  output logic [NUM_REQ-1:0]                req_done,
  output logic [8*NUMBER_BITS-1:0]          req_result,
  output logic                              busy,
  output logic [REQ_IDX_BITS-1:0]           grant_idx,
  output logic [8*NUMBER_BITS-1:0]          mult_a,
  output logic [8*NUMBER_BITS-1:0]          mult_b,
  output logic                              mult_ready,
  input  logic                              mult_done,
  input  logic [8*NUMBER_BITS-1:0]          mult_result
);

  // One operand matrix: 4 complex elements of two components each.
  localparam int MAT_BITS = 8 * NUMBER_BITS;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [REQ_IDX_BITS-1:0]   last_grant_q, last_grant_d;
  logic [REQ_IDX_BITS-1:0]   grant_idx_q, grant_idx_d;
  logic [MAT_BITS-1:0]       mult_a_q, mult_a_d;
  logic [MAT_BITS-1:0]       mult_b_q, mult_b_d;
  logic                      mult_ready_q, mult_ready_d;
  logic [NUM_REQ-1:0]        req_grant_q, req_grant_d;
  logic [NUM_REQ-1:0]        req_done_q, req_done_d;
  logic [MAT_BITS-1:0]       req_result_q, req_result_d;
  logic                      done_last_q;

  logic                      done_rise;
  logic                      pick_found;
  logic [REQ_IDX_BITS-1:0]   pick_idx;
  logic [REQ_IDX_BITS-1:0]   cand_idx;

  // Per-requester operand views so the winner can be selected by index.
  logic [MAT_BITS-1:0]       a_slice [NUM_REQ];
  logic [MAT_BITS-1:0]       b_slice [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign a_slice[gi] = req_a[gi*MAT_BITS +: MAT_BITS];
      assign b_slice[gi] = req_b[gi*MAT_BITS +: MAT_BITS];
    end
  endgenerate

  // Completion is the rising edge of the multiplier's done level, so a level
  // that is already high when we start waiting is never taken as a result.
  assign done_rise = mult_done & ~done_last_q;

  // Round-robin pick: first active request scanning upward from the slot
  // after the last completed grant, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = REQ_IDX_BITS'((int'(last_grant_q) + k) % NUM_REQ);
      if (!pick_found && req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Next-state and output logic; pulses default low, held values hold.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_idx_d  = grant_idx_q;
    mult_a_d     = mult_a_q;
    mult_b_d     = mult_b_q;
    mult_ready_d = 1'b0;
    req_grant_d  = '0;
    req_done_d   = '0;
    req_result_d = req_result_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          mult_a_d              = a_slice[pick_idx];
          mult_b_d              = b_slice[pick_idx];
          grant_idx_d           = pick_idx;
          req_grant_d[pick_idx] = 1'b1;
          mult_ready_d          = 1'b1;
          state_d               = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Requests are ignored here; only the completion edge matters.
        if (done_rise) begin
          req_result_d            = mult_result;
          req_done_d[grant_idx_q] = 1'b1;
          last_grant_d            = grant_idx_q;
          state_d                 = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything and drops any
  // in-flight multiplication without reporting it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ_IDX_BITS'(NUM_REQ - 1);
      grant_idx_q  <= '0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      mult_ready_q <= 1'b0;
      req_grant_q  <= '0;
      req_done_q   <= '0;
      req_result_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_idx_q  <= grant_idx_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      mult_ready_q <= mult_ready_d;
      req_grant_q  <= req_grant_d;
      req_done_q   <= req_done_d;
      req_result_q <= req_result_d;
    end
  end

  // Edge-detect history tracks mult_done even through reset, so a level that
  // is high when reset releases is still treated as stale.
  always_ff @(posedge clk) begin
    done_last_q <= mult_done;
  end

  assign busy       = (state_q != ST_IDLE);
  assign grant_idx  = grant_idx_q;
  assign mult_a     = mult_a_q;
  assign mult_b     = mult_b_q;
  assign mult_ready = mult_ready_q;
  assign req_grant  = req_grant_q;
  assign req_done   = req_done_q;
  assign req_result = req_result_q;

endmodule

// File: doc/multiplier_arbiter.md
Name: multiplier_arbiter

Overview:
- Shares the single complex 2x2 matrix multiplier between NUM_REQ requesters, for example several sequence-multiplier lanes running in parallel.
- Arbitrates round-robin, registers the winning operands, and drives the multiplier's ready/done handshake.
- Captures the product and returns it to the granted requester with a one-cycle done pulse.
- Sits between the requester lanes and the multiplier; the requesters no longer connect to the multiplier directly.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- REQ_IDX_BITS, 2, width of the grant index; must equal clog2(NUM_REQ).
- NUMBER_BITS, 18, signed fixed-point width of one real or imaginary component. Set it to the codebase NUMBER_BITS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req  in  NUM_REQ  per-requester request level.
- req_a  in  NUM_REQ*8*NUMBER_BITS  left operands. Requester i occupies slice i. Element order inside a slice is [row][col][re/im], flattened row-major, lowest index at LSB.
- req_b  in  NUM_REQ*8*NUMBER_BITS  right operands, same layout as req_a.
- req_grant  out  NUM_REQ  one-hot, one-cycle pulse when a requester's operands are taken.
- req_done  out  NUM_REQ  one-hot, one-cycle pulse when that requester's result is valid.
- req_result  out  8*NUMBER_BITS  shared result bus, same layout as one operand slice.
- busy  out  1  high in any state other than IDLE.
- grant_idx  out  REQ_IDX_BITS  index of the current or most recent grant.
- mult_a  out  8*NUMBER_BITS  registered operand A to the multiplier.
- mult_b  out  8*NUMBER_BITS  registered operand B to the multiplier.
- mult_ready  out  1  start pulse to the multiplier.
- mult_done  in  1  multiplier done level; completion is its rising edge.
- mult_result  in  8*NUMBER_BITS  multiplier product.

Behaviour:

Reset values:
- All outputs are 0, state is IDLE, and the round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- done_last is loaded from mult_done every cycle, including during reset.

States:
- IDLE, when any req bit is high:
  - Select the first set bit scanning upward from last_grant+1, wrapping modulo NUM_REQ.
  - Register that requester's req_a/req_b slices into mult_a/mult_b and set grant_idx.
  - Pulse req_grant[idx] and mult_ready for one cycle, then go to WAIT.
- IDLE, when no req bit is high: stay in IDLE; all pulses are 0.
- WAIT:
  - mult_ready = 0.
  - On mult_done high with done_last low: register mult_result into req_result, pulse req_done[grant_idx], set last_grant = grant_idx, return to IDLE.

Latency:
- If req is sampled in IDLE at cycle T, then at T+1 req_grant, mult_ready and mult_a/mult_b are all valid.
- If the rising edge of mult_done is sampled at cycle E, then at E+1 req_done and req_result are valid and the state is IDLE.
- The next mult_ready can occur at E+2 at the earliest.

Requester rules:
- req is ignored outside IDLE.
- A requester drops req on the cycle after it sees its grant. If req is still high in IDLE after req_done, it is a new request.
- Operands may change immediately after the grant, because they are registered.

Held values:
- req_result and grant_idx hold until the next completion or grant.
- mult_a/mult_b hold until the next grant.

Boundary conditions:
- mult_done already high when WAIT is entered (stale level): no completion until it falls and rises again.
- All requesters active: strict rotation 0,1,2,3,0,... with no starvation.
- Only one requester active: it is granted back-to-back with no penalty.
- reset mid-WAIT: return to IDLE and reset all outputs. The in-flight result is discarded and no req_done is issued.
- Simultaneous req edge and completion: the completion is handled first. A new grant occurs no earlier than the IDLE cycle that follows.

Test Plan:
- After reset, req=4'b0001 with A = identity and B = Hadamard: mult_ready at T+1 with mult_a = identity. The model multiplier raises done 3 cycles later. req_done = 4'b0001 one cycle after that edge, and req_result equals the Hadamard matrix.
- req=4'b1111 held, with each requester re-asserting after its done: grant sequence is 0,1,2,3,0. Each req_grant is one-hot and each req_done matches the preceding grant_idx.
- Requester 2 is served, then req=4'b0101: requester 0 wins (wrap from last_grant=2), then requester 2.
- mult_done is held high across a grant: no req_done until mult_done falls and then rises. Exactly one req_done is produced.
- reset asserted 2 cycles into WAIT: all outputs are 0 the next cycle, no req_done occurs, and a later req=4'b0010 is granted normally.
- The requester changes req_a the cycle after its grant: mult_a is unchanged, and the product uses the original operands.
